// File: rtl/alu_job_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_job_arbiter_if
//  Purpose  : Job request / response and ALU-core signal bundle for the
//             two-requester ALU job arbiter.
//  Revision : 1.0
// ============================================================================
interface alu_job_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [1:0][1:0]       req_op;
    logic [1:0][WIDTH-1:0] req_a;
    logic [1:0][WIDTH-1:0] req_q;
    logic [1:0][WIDTH-1:0] req_m;

    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_id;
    logic [WIDTH-1:0]      resp_hi;
    logic [WIDTH-1:0]      resp_lo;
    logic                  resp_err;

    logic                  alu_begin;
    logic [1:0]            alu_op;
    logic                  alu_rst_n;
    logic [WIDTH-1:0]      alu_inbus;
    logic                  alu_loadA;
    logic                  alu_loadQ;
    logic                  alu_loadM;
    logic                  alu_pushA;
    logic                  alu_pushQ;
    logic [WIDTH-1:0]      alu_outbus;
    logic                  alu_end;

    // Arbiter side
    modport slave (
        input  req_valid, req_op, req_a, req_q, req_m,
        output req_ready,
        output resp_valid, resp_id, resp_hi, resp_lo, resp_err,
        input  resp_ready,
        output alu_begin, alu_op, alu_rst_n, alu_inbus,
        input  alu_loadA, alu_loadQ, alu_loadM, alu_pushA, alu_pushQ,
        input  alu_outbus, alu_end
    );

    // Requesters, response consumer and ALU core side
    modport master (
        output req_valid, req_op, req_a, req_q, req_m,
        input  req_ready,
        input  resp_valid, resp_id, resp_hi, resp_lo, resp_err,
        output resp_ready,
        input  alu_begin, alu_op, alu_rst_n, alu_inbus,
        output alu_loadA, alu_loadQ, alu_loadM, alu_pushA, alu_pushQ,
        output alu_outbus, alu_end
    );
endinterface
`default_nettype wire

// File: rtl/alu_job_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_job_arbiter
//  Purpose  : Round-robin sequencer sharing one ALU core between two
//             requesters, with operand steering, result capture and watchdog.
//  Revision : 1.0
// ============================================================================
module alu_job_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  wire logic         clk,
    input  wire logic         reset,
    alu_job_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_RUN    = 3'd2,
        ST_ABORT0 = 3'd3,
        ST_ABORT1 = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    // RUN lasts at most TIMEOUT cycles; the last legal count is TIMEOUT-1
    localparam logic [15:0] c_cnt_last = 16'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_state_next;

    logic             r_last_grant;
    logic             r_id;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_err;
    logic [15:0]      r_cnt;

    logic             w_grant_valid;
    logic             w_grant_idx;
    logic [1:0]       w_req_ready;
    logic [WIDTH-1:0] w_inbus;
    logic             w_cnt_expired;

    assign w_cnt_expired = (r_cnt == c_cnt_last);

    // Grant selection: a lone requester wins; on contention the one not
    // served last time wins.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_idx   = 1'b0;
        if (r_state == ST_IDLE) begin
            case (bus.req_valid)
                2'b01: begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = 1'b0;
                end
                2'b10: begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = 1'b1;
                end
                2'b11: begin
                    w_grant_valid = 1'b1;
                    w_grant_idx   = ~r_last_grant;
                end
                default: begin
                    w_grant_valid = 1'b0;
                    w_grant_idx   = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_req_ready = 2'b00;
        if (w_grant_valid) begin
            w_req_ready[w_grant_idx] = 1'b1;
        end
    end

    // Operand steering only while the core is running a job
    always_comb begin
        w_inbus = '0;
        if (r_state == ST_RUN) begin
            if (bus.alu_loadA) begin
                w_inbus = r_a;
            end else if (bus.alu_loadQ) begin
                w_inbus = r_q;
            end else if (bus.alu_loadM) begin
                w_inbus = r_m;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (bus.alu_end) begin
                    w_state_next = ST_RESP;
                end else if (w_cnt_expired) begin
                    w_state_next = ST_ABORT0;
                end
            end
            ST_ABORT0: begin
                w_state_next = ST_ABORT1;
            end
            ST_ABORT1: begin
                w_state_next = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_op         <= 2'b00;
            r_a          <= '0;
            r_q          <= '0;
            r_m          <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_last_grant <= w_grant_idx;
                        r_id         <= w_grant_idx;
                        r_op         <= bus.req_op[w_grant_idx];
                        r_a          <= bus.req_a[w_grant_idx];
                        r_q          <= bus.req_q[w_grant_idx];
                        r_m          <= bus.req_m[w_grant_idx];
                    end
                end
                ST_START: begin
                    r_cnt <= '0;
                    r_hi  <= '0;
                    r_lo  <= '0;
                    r_err <= 1'b0;
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + 16'd1;
                    // Pushes are captured even in the END cycle
                    if (bus.alu_pushA) begin
                        r_hi <= bus.alu_outbus;
                    end
                    if (bus.alu_pushQ) begin
                        r_lo <= bus.alu_outbus;
                    end
                    if (bus.alu_end) begin
                        r_err <= 1'b0;
                    end
                end
                ST_ABORT0, ST_ABORT1: begin
                    r_hi  <= '0;
                    r_lo  <= '0;
                    r_err <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = (r_state == ST_RESP);
    assign bus.resp_id    = r_id;
    assign bus.resp_hi    = r_hi;
    assign bus.resp_lo    = r_lo;
    assign bus.resp_err   = r_err;
    assign bus.alu_begin  = (r_state == ST_START);
    assign bus.alu_op     = r_op;
    assign bus.alu_rst_n  = !((r_state == ST_ABORT0) || (r_state == ST_ABORT1));
    assign bus.alu_inbus  = w_inbus;

endmodule
`default_nettype wire

// File: doc/alu_job_arbiter.md
Name: alu_job_arbiter

Overview:
- Sequencer/arbiter that shares one Paul-ALU core (control unit plus datapath) between two requesters.
- Accepts complete jobs: opcode plus up to three operands. Grants round-robin.
- Drives BEGIN/op_code, places the correct operand on INBUS whenever the control unit strobes a register load, and captures OUTBUS on push strobes.
- Returns a result/status response with a valid/ready handshake. A watchdog recovers a hung core.

Parameters:
- WIDTH, 8, operand/INBUS/OUTBUS width.
- TIMEOUT, 255, maximum cycles from BEGIN to END before abort; legal range 1..65535.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester job valid.
- req_ready  out  2  per-requester job accepted this cycle (one-hot or zero).
- req_op  in  2x2  per-requester op: 00 add, 01 sub, 10 mul, 11 div.
- req_a, req_q, req_m  in  2xWIDTH each  per-requester operands.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  1  requester index of the response.
- resp_hi  out  WIDTH  word from PUSHA.
- resp_lo  out  WIDTH  word from PUSHQ.
- resp_err  out  1  1 = watchdog abort.
- alu_begin  out  1  BEGIN to control unit.
- alu_op  out  2  op_code to control unit.
- alu_rst_n  out  1  active-low control-unit reset.
- alu_inbus  out  WIDTH  INBUS.
- alu_loadA, alu_loadQ, alu_loadM  in  1 each  load strobes from control unit.
- alu_pushA, alu_pushQ  in  1 each  push strobes.
- alu_outbus  in  WIDTH  OUTBUS.
- alu_end  in  1  END.

Behaviour:
- Reset values:
  - state IDLE, req_ready 0, resp_valid 0, resp_id 0, resp_hi 0, resp_lo 0, resp_err 0.
  - alu_begin 0, alu_op 00, alu_rst_n 1, alu_inbus 0, last_grant 1 (requester 0 wins first).
- Arbitration, in IDLE only:
  - If exactly one req_valid is set, grant it.
  - If both are set, grant the index != last_grant.
  - Grant cycle: req_ready[g] = 1 for one cycle. Latch op, a, q, m and id. last_grant <= g. Go to START.
- START, 1 cycle:
  - alu_begin = 1, alu_op = latched op.
  - Clear the watchdog counter, resp_hi and resp_lo. Go to RUN.
- RUN:
  - alu_op is held stable.
  - alu_inbus is combinational: loadA ? a : loadQ ? q : loadM ? m : 0.
  - Operand roles:
    - add/sub: A = x, M = y.
    - mul: Q = multiplicand, M = multiplier.
    - div: A:Q = dividend, M = divisor.
  - On alu_pushA, resp_hi <= alu_outbus. On alu_pushQ, resp_lo <= alu_outbus. Push order is irrelevant.
  - Add/sub leaves resp_lo at 0.
  - The watchdog increments every RUN cycle.
  - On alu_end, go to RESP with err = 0. A push coinciding with END is still captured.
  - If the count reaches TIMEOUT without END, go to ABORT.
- ABORT, 2 cycles:
  - alu_rst_n = 0 in both cycles.
  - resp_hi = resp_lo = 0, err = 1. Then go to RESP.
- RESP:
  - resp_valid = 1. resp_* stay stable until resp_ready.
  - On resp_valid & resp_ready, return to IDLE. The next grant occurs no earlier than the following cycle.
- Requests arriving outside IDLE are held off (req_ready = 0). A requester must keep req_valid and its payload stable until req_ready.
- Duplicate strobes: a load strobe outside RUN is ignored and inbus = 0. A second push of the same register overwrites.
- END outside RUN is ignored.
- Reset mid-job clears everything immediately. The pending job is lost and no response is produced.
- Latency, add with an ideal core: grant at cycle 0, BEGIN at cycle 1, resp_valid the cycle after END.

Test Plan:
- add, req0: op 00, a = 0x12, m = 0x34. INBUS shows 0x12 on loadA and 0x34 on loadM; resp_hi = 0x46, resp_lo = 0x00, resp_id = 0, err = 0.
- mul, req1: q = 0x07, m = 0xFD (-3). Result A:Q = 0xFFEB (-21): resp_hi = 0xFF, resp_lo = 0xEB.
- div, req0: A:Q = 0x0064 (100), m = 0x07. Quotient 14 and remainder 2: resp_lo = 0x0E, resp_hi = 0x02. Q is pushed before A.
- Contention: both requesters valid every cycle over 4 jobs. Grants are 0, 1, 0, 1; resp_id matches; req_ready is never both set.
- Watchdog: TIMEOUT = 20 and the core model never raises END. alu_rst_n is low for 2 cycles starting at RUN cycle 20; resp_err = 1 with zero data; next job proceeds normally.
- Backpressure and reset:
  - resp_ready held 0 for 10 cycles: response stable, no new grant.
  - Then assert reset during RUN of a new job: all outputs return to reset values asynchronously and there is no response.
